// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: CPU (port 0) and debug/loader (port 1).
// Round-robin by default; define CPU_PRIORITY_EN to make port 0 win every tie.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic                           m0_req,
  input  logic                           m0_we,
  input  logic [ADDR_W-1:0]              m0_addr,
  input  logic [DATA_W-1:0]              m0_wdata,
  input  logic [DATA_W/8-1:0]            m0_be,
  output logic                           m0_gnt,
  output logic                           m0_rvalid,
  output logic [DATA_W-1:0]              m0_rdata,
  output logic                           m0_err,

  input  logic                           m1_req,
  input  logic                           m1_we,
  input  logic [ADDR_W-1:0]              m1_addr,
  input  logic [DATA_W-1:0]              m1_wdata,
  input  logic [DATA_W/8-1:0]            m1_be,
  output logic                           m1_gnt,
  output logic                           m1_rvalid,
  output logic [DATA_W-1:0]              m1_rdata,
  output logic                           m1_err,

  output logic                           mem_en,
  output logic                           mem_we,
  output logic [DATA_W/8-1:0]            mem_be,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int MEM_AW = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] WORD_LIMIT = WORD_W'(DEPTH_WORDS);

  logic                 last_grant;
  logic                 resp_pending;
  logic                 resp_owner;
  logic                 resp_read;
  logic                 resp_err;

  logic                 pick1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 any_gnt;

  logic                 sel_we;
  logic [WORD_W-1:0]    sel_word;
  logic [DATA_W-1:0]    sel_wdata;
  logic [DATA_W/8-1:0]  sel_be;
  logic                 sel_in_range;

  logic                 resp_pulse;
  logic [DATA_W-1:0]    resp_data;

  // Byte lanes are selected by the enables, so the low address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  always_comb begin
    pick1 = 1'b0;
`ifdef CPU_PRIORITY_EN
    pick1 = m1_req && !m0_req;
`else
    pick1 = m1_req && (!m0_req || !last_grant);
`endif
    gnt0    = rst && m0_req && !pick1;
    gnt1    = rst && pick1;
    any_gnt = gnt0 || gnt1;
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    sel_we    = m0_we;
    sel_word  = m0_addr[ADDR_W-1:2];
    sel_wdata = m0_wdata;
    sel_be    = m0_be;
    if (gnt1) begin
      sel_we    = m1_we;
      sel_word  = m1_addr[ADDR_W-1:2];
      sel_wdata = m1_wdata;
      sel_be    = m1_be;
    end
    sel_in_range = (sel_word < WORD_LIMIT);
  end

  // Out-of-range accesses never reach the RAM; they are answered with an error instead.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (any_gnt && sel_in_range) begin
      mem_en    = 1'b1;
      mem_we    = sel_we;
      mem_be    = sel_we ? sel_be : '0;
      mem_addr  = sel_word[MEM_AW-1:0];
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant   <= 1'b1;
      resp_pending <= 1'b0;
      resp_owner   <= 1'b0;
      resp_read    <= 1'b0;
      resp_err     <= 1'b0;
    end else begin
      resp_pending <= any_gnt;
      if (any_gnt) begin
        last_grant <= gnt1;
        resp_owner <= gnt1;
        resp_read  <= !sel_we;
        resp_err   <= !sel_in_range;
      end
    end
  end

  // Clean in-range writes complete silently; reads and errors get exactly one pulse.
  always_comb begin
    resp_pulse = resp_pending && (resp_read || resp_err);
    resp_data  = (resp_pending && resp_read && !resp_err) ? mem_rdata : '0;
    m0_rvalid  = resp_pulse && !resp_owner;
    m1_rvalid  = resp_pulse && resp_owner;
    m0_err     = m0_rvalid && resp_err;
    m1_err     = m1_rvalid && resp_err;
    m0_rdata   = m0_rvalid ? resp_data : '0;
    m1_rdata   = m1_rvalid ? resp_data : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a response scoreboard.
// Honours CPU_PRIORITY_EN for the arbitration expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  logic [31:0] ram [0:63];
  logic        ram_loaded = 1'b0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered single-port RAM; word i starts out as 0xA000_0000 | i.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 | 32'(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] e0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] e1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = e0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = e1;
    #1;
  endtask

  task automatic check_output(input string tag);
    resp_t e;
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        chk({tag, "_spurious_rvalid"}, {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_rvalid0"}, {31'b0, m0_rvalid}, {31'b0, !e.port});
        chk({tag, "_rvalid1"}, {31'b0, m1_rvalid}, {31'b0, e.port});
        chk({tag, "_rdata"}, e.port ? m1_rdata : m0_rdata, e.rdata);
        chk({tag, "_err"}, {31'b0, e.port ? m1_err : m0_err}, {31'b0, e.err});
      end
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_missing_rvalid"}, {31'b0, m0_rvalid | m1_rvalid}, 32'd1);
      end
      chk({tag, "_idle_err"}, {30'b0, m1_err, m0_err}, 32'd0);
    end
  endtask

  task automatic expect_grant(input string tag, input logic g0, input logic g1, input logic push,
                              input logic port, input logic [31:0] rdata, input logic err);
    resp_t e;
    chk({tag, "_gnt0"}, {31'b0, m0_gnt}, {31'b0, g0});
    chk({tag, "_gnt1"}, {31'b0, m1_gnt}, {31'b0, g1});
    if (push) begin
      e.port = port; e.rdata = rdata; e.err = err;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_output(tag);
  endtask

  initial begin
    logic g1;
    rst = 1'b0;
    apply_stimulus(1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_err", {30'b0, m1_err, m0_err}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);

    // First tie after reset goes to port 0
    rst = 1'b1;
    apply_stimulus(1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0, 4'h0);
    expect_grant("first_tie", 1, 0, 1, 0, 32'hA000_0000, 0);

    // Write then read-after-write on word 0
    apply_stimulus(1, 1, 32'h0, 32'h0000_0019, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0);
    chk("wr_mem_en", {31'b0, mem_en}, 32'd1);
    chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
    chk("wr_mem_be", {28'b0, mem_be}, 32'hF);
    chk("wr_mem_addr", {26'b0, mem_addr}, 32'd0);
    chk("wr_mem_wdata", mem_wdata, 32'h0000_0019);
    expect_grant("wr0", 1, 0, 0, 0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0);
    chk("rd_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rd_mem_be", {28'b0, mem_be}, 32'd0);
    expect_grant("raw0", 1, 0, 1, 0, 32'h0000_0019, 0);

    // Port 1 alone, leaving last_grant on port 1 before the contention run
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h8, 32'h0, 4'h0);
    expect_grant("m1_solo", 0, 1, 1, 1, 32'hA000_0002, 0);

    for (int i = 0; i < 4; i++) begin
`ifdef CPU_PRIORITY_EN
      g1 = 1'b0;
`else
      g1 = (i % 2 == 1);
`endif
      apply_stimulus(1, 0, 32'h4, 32'h0, 4'h0, 1, 0, 32'h8, 32'h0, 4'h0);
      expect_grant("contend", !g1, g1, 1, g1, g1 ? 32'hA000_0002 : 32'hA000_0001, 0);
    end

    // Partial byte write on word 2
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h8, 32'h1122_3344, 4'hF);
    expect_grant("be_full", 0, 1, 0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h8, 32'hAABB_CCDD, 4'b0001);
    expect_grant("be_byte0", 0, 1, 0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h8, 32'h0, 4'h0);
    expect_grant("be_read", 0, 1, 1, 1, 32'h1122_33DD, 0);

    // Range boundary: word 63 is the last valid word, 64 and 65 are errors
    apply_stimulus(1, 0, 32'h100, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    chk("oor_rd_mem_en", {31'b0, mem_en}, 32'd0);
    expect_grant("oor_rd", 1, 0, 1, 0, 32'h0, 1);
    apply_stimulus(1, 1, 32'h104, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0);
    chk("oor_wr_mem_en", {31'b0, mem_en}, 32'd0);
    expect_grant("oor_wr", 1, 0, 1, 0, 32'h0, 1);
    apply_stimulus(1, 0, 32'h4, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    expect_grant("oor_wr_dropped", 1, 0, 1, 0, 32'hA000_0001, 0);
    apply_stimulus(1, 0, 32'hFC, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    chk("last_word_mem_en", {31'b0, mem_en}, 32'd1);
    chk("last_word_mem_addr", {26'b0, mem_addr}, 32'd63);
    expect_grant("last_word", 1, 0, 1, 0, 32'hA000_003F, 0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'hFFFF_FFFC, 32'h0, 4'h0);
    expect_grant("m1_oor_rd", 0, 1, 1, 1, 32'h0, 1);

    // Reset lands between a port-1 read grant and its response
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h8, 32'h0, 4'h0);
    chk("pre_rst_gnt1", {31'b0, m1_gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(1, 0, 32'h8, 32'h0, 4'h0, 1, 0, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    chk("mid_rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("mid_rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    chk("mid_rst_mem_en", {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1, 0, 32'h8, 32'h0, 4'h0, 1, 0, 32'h4, 32'h0, 4'h0);
    expect_grant("post_rst_tie", 1, 0, 1, 0, 32'h1122_33DD, 0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h4, 32'h0, 4'h0);
    expect_grant("post_rst_m1", 0, 1, 1, 1, 32'hA000_0001, 0);

    apply_stimulus(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    expect_grant("idle", 0, 0, 0, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
